// File: rtl/apb_dmem_responder_pkg.sv
// Shared types and constants for the dmem APB responder.
package apb_dmem_responder_pkg;

    typedef enum logic [1:0] {
        RSP_IDLE = 2'd0,
        RSP_WAIT = 2'd1,
        RSP_RESP = 2'd2
    } dmem_rsp_state_e;

    // Wait counter must hold WAIT_CYCLES (0..15) plus the optional random 0..3.
    localparam int unsigned DMEM_CNT_W = 5;

    localparam logic [7:0] DMEM_LFSR_SEED = 8'hA5;

    // One step of the x^8+x^6+x^5+x^4+1 Fibonacci LFSR.
    function automatic logic [7:0] dmem_lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/apb_dmem_responder_if.sv
// APB4 link between the load/store unit (master) and the dmem responder (slave).
interface apb_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_dmem_responder_sram.sv
// Single-port synchronous data SRAM with byte enables; read data lands the
// cycle after i_en. INIT_FILE names the hex preload image the platform loads.
module dmem_sram #(
    parameter int unsigned DEPTH     = 1024,
    parameter string       INIT_FILE = "",
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Byte-lane write or full-word read; contents are never reset.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/apb_dmem_responder.sv
// APB4 completer in front of the data SRAM: range/strobe checking, byte-lane
// writes and programmable wait states.
// Optional build macro: DMEM_RAND_WAIT_EN adds a 0..3 LFSR-driven extra wait
// per access.
module apb_dmem_responder
    import apb_dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic  clk,
    input  logic  rst_n,
    apb_if.slave  apb
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [32:0] END_ADDR = 33'(BASE_ADDR) + 33'(DEPTH) * 33'd4;

    dmem_rsp_state_e        r_state, w_state_nxt;
    logic [DMEM_CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_init;
    logic [AW-1:0]          r_idx;
    logic                   r_write, r_err, r_pready, r_pslverr, r_rd_ok;
    logic [31:0]            r_wdata, w_sram_rdata;
    logic [3:0]             r_strb;
    logic                   w_setup, w_in_range, w_err, w_capture, w_sram_en;

    assign w_setup    = apb.psel && !apb.penable;
    assign w_in_range = ({1'b0, apb.paddr} >= 33'(BASE_ADDR)) && ({1'b0, apb.paddr} < END_ADDR);
    assign w_err      = !w_in_range || (apb.pwrite && (apb.pstrb == 4'b0000));

`ifdef DMEM_RAND_WAIT_EN
    logic [7:0] r_lfsr;

    // LFSR steps once per accepted setup; its low bits extend that access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_lfsr <= DMEM_LFSR_SEED;
        else if (w_capture) r_lfsr <= dmem_lfsr_next(r_lfsr);
    end

    assign w_cnt_init = DMEM_CNT_W'(WAIT_CYCLES) + DMEM_CNT_W'(r_lfsr[1:0]);
`else
    assign w_cnt_init = DMEM_CNT_W'(WAIT_CYCLES);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= RSP_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state, wait countdown and SRAM issue.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_sram_en   = 1'b0;
        case (r_state)
            RSP_IDLE: begin
                if (w_setup) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = w_cnt_init;
                    w_state_nxt = RSP_WAIT;
                end
            end
            RSP_WAIT: begin
                if (!apb.psel) begin
                    w_state_nxt = RSP_IDLE;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - DMEM_CNT_W'(1);
                end else begin
                    w_sram_en   = !r_err;
                    w_state_nxt = RSP_RESP;
                end
            end
            RSP_RESP: w_state_nxt = RSP_IDLE;
            default:  w_state_nxt = RSP_IDLE;
        endcase
    end

    // Transfer capture at setup; fields hold through WAIT. BASE_ADDR is
    // DEPTH*4 aligned, so the word index is a plain slice of paddr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_capture) begin
                r_idx   <= apb.paddr[AW+1:2];
                r_write <= apb.pwrite;
                r_wdata <= apb.pwdata;
                r_strb  <= apb.pstrb;
                r_err   <= w_err;
            end
        end
    end

    // Response flags are high only for the single RESP cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_rd_ok   <= 1'b0;
        end else begin
            r_pready  <= (w_state_nxt == RSP_RESP);
            r_pslverr <= (w_state_nxt == RSP_RESP) && r_err;
            r_rd_ok   <= (w_state_nxt == RSP_RESP) && !r_err && !r_write;
        end
    end

    dmem_sram #(
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_sram (
        .clk     (clk),
        .i_en    (w_sram_en),
        .i_we    (r_write),
        .i_be    (r_strb),
        .i_addr  (r_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_sram_rdata)
    );

    assign apb.pready  = r_pready;
    assign apb.pslverr = r_pslverr;
    assign apb.prdata  = r_rd_ok ? w_sram_rdata : 32'h0;

endmodule

// File: tb/tb_apb_dmem_responder.sv
// Directed + random bench for apb_dmem_responder: one instance with zero wait
// states (sel 0) and one with three (sel 1), checked against a word model.
module tb_apb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0001_0000;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk, rst_n;
    apb_if bus0();
    apb_if bus3();

    apb_dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0), .INIT_FILE(""))
        u_dut0 (.clk(clk), .rst_n(rst_n), .apb(bus0));
    apb_dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(3), .INIT_FILE(""))
        u_dut3 (.clk(clk), .rst_n(rst_n), .apb(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    exp_t        sb_q[$];
    logic [31:0] mdl [2][DEPTH];
    int          lat_min[2] = '{99, 99};
    int          lat_max[2] = '{0, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_bus(input int sel, input logic sl, input logic en, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] st);
        if (sel == 0) begin
            bus0.psel = sl; bus0.penable = en; bus0.pwrite = wr;
            bus0.paddr = addr; bus0.pwdata = wd; bus0.pstrb = st;
        end else begin
            bus3.psel = sl; bus3.penable = en; bus3.pwrite = wr;
            bus3.paddr = addr; bus3.pwdata = wd; bus3.pstrb = st;
        end
    endtask

    task automatic get_rsp(input int sel, output logic rdy, output logic [31:0] rd, output logic err);
        if (sel == 0) begin rdy = bus0.pready; rd = bus0.prdata; err = bus0.pslverr; end
        else          begin rdy = bus3.pready; rd = bus3.prdata; err = bus3.pslverr; end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (st[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // Full APB transfer starting right after a rising edge; returns to idle
    // after the response so that a following call runs back-to-back.
    task automatic xfer(input int sel, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] st, input string tag);
        longint      a;
        logic        err, rdy, perr;
        logic [31:0] rd;
        int          idx, lat, w, lo, hi;
        exp_t        e;
        a   = longint'(addr);
        err = (a < longint'(BASE)) || (a >= longint'(BASE) + longint'(DEPTH) * 4)
              || (wr && st == 4'b0000);
        idx = err ? 0 : int'((addr - BASE) >> 2);
        e.err  = err;
        e.data = (!wr && !err) ? mdl[sel][idx] : 32'h0;
        sb_q.push_back(e);
        if (wr && !err) mdl[sel][idx] = merge(mdl[sel][idx], wd, st);
        w  = (sel == 0) ? 0 : 3;
        lo = w + 2;
`ifdef DMEM_RAND_WAIT_EN
        hi = w + 5;
`else
        hi = w + 2;
`endif
        set_bus(sel, 1'b1, 1'b0, wr, addr, wd, st);
        @(posedge clk); #1;
        set_bus(sel, 1'b1, 1'b1, wr, addr, wd, st);
        lat = 0;
        rdy = 1'b0; rd = '0; perr = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            get_rsp(sel, rdy, rd, perr);
            if (rdy) begin lat = k; break; end
            @(posedge clk); #1;
        end
        n_checks++;
        assert (lat >= lo && lat <= hi) n_pass++;
        else $error("FAIL %s_lat: observed %0d expected %0d..%0d", tag, lat, lo, hi);
        if (lat < lat_min[sel]) lat_min[sel] = lat;
        if (lat > lat_max[sel]) lat_max[sel] = lat;
        e = sb_q.pop_front();
        chk({tag, "_prdata"}, rd, e.data);
        chk({tag, "_pslverr"}, 32'(perr), 32'(e.err));
        @(posedge clk); #1;
        set_bus(sel, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Watch pready over a window where no response may appear.
    task automatic quiet(input int sel, input int cycles, input string tag);
        logic rdy, perr, seen;
        logic [31:0] rd;
        seen = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            get_rsp(sel, rdy, rd, perr);
            if (rdy) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'h0);
    endtask

    initial begin
        logic rdy, perr;
        logic [31:0] rd;
        int sel, word;
        logic wr;
        logic [31:0] addr;
        logic [3:0] st;

        rst_n = 1'b0;
        set_bus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_bus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset values on both instances.
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            get_rsp(s, rdy, rd, perr);
            chk("rst_pready", 32'(rdy), 32'h0);
            chk("rst_prdata", rd, 32'h0);
            chk("rst_pslverr", 32'(perr), 32'h0);
        end
        @(posedge clk); #1;

        // Zero wait states: full-word write and readback.
        xfer(0, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, "w0_full");
        xfer(0, 1'b0, BASE + 32'h10, 32'h0, 4'h0, "r0_full");

        // Single byte lane over an existing word; paddr[1:0] ignored.
        xfer(0, 1'b1, BASE + 32'h10, 32'h1122_3344, 4'hF, "w0_base");
        xfer(0, 1'b1, BASE + 32'h11, 32'h0000_5A00, 4'b0010, "w0_byte");
        xfer(0, 1'b0, BASE + 32'h10, 32'h0, 4'hF, "r0_byte");
        chk("byte_model", mdl[0][4], 32'h1122_5A44);

        // Range and strobe errors; memory must survive the zero-strobe write.
        xfer(0, 1'b0, BASE + DEPTH * 4, 32'h0, 4'h0, "r0_above");
        xfer(0, 1'b0, BASE - 32'h4, 32'h0, 4'h0, "r0_below");
        xfer(0, 1'b0, BASE + DEPTH * 4 - 32'h1, 32'h0, 4'h0, "r0_lastbyte_wr");
        xfer(0, 1'b1, BASE + DEPTH * 4 - 32'h4, 32'hCAFE_F00D, 4'hF, "w0_last");
        xfer(0, 1'b0, BASE + DEPTH * 4 - 32'h1, 32'h0, 4'h0, "r0_last");
        xfer(0, 1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'h0, "w0_nostrb");
        xfer(0, 1'b0, BASE + 32'h10, 32'h0, 4'h0, "r0_after_nostrb");

        // Three wait states, back-to-back write then read of the same word.
        xfer(1, 1'b1, BASE + 32'h40, 32'h0BAD_CAFE, 4'hF, "w3_a");
        xfer(1, 1'b0, BASE + 32'h40, 32'h0, 4'h0, "r3_a");
        xfer(1, 1'b1, BASE + 32'h40, 32'h1234_5678, 4'b1001, "w3_b");
        xfer(1, 1'b0, BASE + 32'h40, 32'h0, 4'h0, "r3_b");

        // psel drop during WAIT: no response, no write, FSM idles again.
        set_bus(1, 1'b1, 1'b0, 1'b1, BASE + 32'h40, 32'h5555_5555, 4'hF);
        @(posedge clk); #1;
        set_bus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        quiet(1, 8, "abort_pready");
        @(posedge clk); #1;
        xfer(1, 1'b0, BASE + 32'h40, 32'h0, 4'h0, "r3_after_abort");

        // Reset pulse during WAIT of a write: no response, word unchanged.
        set_bus(1, 1'b1, 1'b0, 1'b1, BASE + 32'h40, 32'hAAAA_AAAA, 4'hF);
        @(posedge clk); #1;
        set_bus(1, 1'b1, 1'b1, 1'b1, BASE + 32'h40, 32'hAAAA_AAAA, 4'hF);
        @(posedge clk); #1;
        rst_n = 1'b0;
        set_bus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #3 rst_n = 1'b1;
        quiet(1, 8, "rst_pready");
        @(posedge clk); #1;
        xfer(1, 1'b0, BASE + 32'h40, 32'h0, 4'h0, "r3_after_rst");

        // Random traffic over a small pre-written window on both instances.
        lat_min = '{99, 99};
        lat_max = '{0, 0};
        for (int s = 0; s < 2; s++) begin
            for (int w = 64; w < 80; w++) begin
                xfer(s, 1'b1, BASE + 32'(w * 4), $urandom, 4'hF, "rnd_init");
            end
        end
        for (int n = 0; n < 200; n++) begin
            sel  = int'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            word = 64 + int'($urandom_range(0, 15));
            addr = BASE + 32'(word * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) addr = BASE + DEPTH * 4 + 32'(word * 4);
            st   = 4'($urandom_range(0, 15));
            xfer(sel, wr, addr, $urandom, st, "rnd");
        end
`ifdef DMEM_RAND_WAIT_EN
        chk("lat_min0", 32'(lat_min[0]), 32'd2);
        chk("lat_max0", 32'(lat_max[0]), 32'd5);
        chk("lat_min3", 32'(lat_min[1]), 32'd5);
        chk("lat_max3", 32'(lat_max[1]), 32'd8);
`else
        chk("lat_min0", 32'(lat_min[0]), 32'd2);
        chk("lat_min3", 32'(lat_min[1]), 32'd5);
`endif
        chk("sb_empty", 32'(sb_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
